// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem reads, and feeds IF/ID through a
// one-entry skid buffer. Handles redirects (including one arriving mid-miss) and halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        fetch_valid,
  output logic        halted
);

  typedef enum logic [1:0] {StFetch, StDrain, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_npc_q, buf_npc_d;

  logic [31:0] pc_plus4;
  logic        req;

  assign pc_plus4 = pc_q + 32'd4;
  // Request is derived from state only; reset gating is applied at the port.
  assign req = ((state_q == StFetch) && !buf_valid_q) || (state_q == StDrain);

  always_comb begin
    imemREN     = req && !RST;
    imemaddr    = pc_q;
    instr       = buf_valid_q ? buf_instr_q : imemload;
    npc         = buf_valid_q ? buf_npc_q : pc_plus4;
    fetch_valid = (buf_valid_q || (ihit && req && (state_q == StFetch)))
                  && !redirect_en && !RST;
    halted      = (state_q == StHalted);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_npc_d   = buf_npc_q;
    case (state_q)
      StFetch: begin
        if (redirect_en && req && !ihit) begin
          // Outstanding request cannot be aborted; wait for its response first.
          target_d    = redirect_pc;
          buf_valid_d = 1'b0;
          state_d     = StDrain;
        end else if (redirect_en) begin
          pc_d        = redirect_pc;
          buf_valid_d = 1'b0;
        end else if (halt) begin
          state_d     = StHalted;
          buf_valid_d = 1'b0;
        end else if (buf_valid_q) begin
          if (!stall) buf_valid_d = 1'b0;
        end else if (ihit) begin
          pc_d = pc_plus4;
          if (stall) begin
            buf_instr_d = imemload;
            buf_npc_d   = pc_plus4;
            buf_valid_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (redirect_en) target_d = redirect_pc;
        if (ihit) begin
          pc_d    = redirect_en ? redirect_pc : target_q;
          state_d = StFetch;
        end
      end
      StHalted: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StFetch;
      pc_q        <= PC_INIT;
      target_q    <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_npc_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_npc_q   <= buf_npc_d;
    end
  end

endmodule
